// File: rtl/fos_out_decim.sv
// fos_out_decim
//   Output stage behind the first-order IIR section.
//   - Takes one signed filter sample per enabled clock.
//   - Averages each block of 2^LOG2_N samples (boxcar) into one decimated sample.
//   - Queues the decimated samples in a small show-ahead FIFO.
//   - Hands them to the consumer over a valid/ready handshake.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   y_in      signed filter output sample
//   in_en     y_in is valid this cycle
//   m_data    decimated sample at the FIFO head; 0 while m_valid is low
//   m_valid   FIFO holds at least one result
//   m_ready   consumer takes m_data on this edge
//   level     FIFO occupancy, 0..2^FIFO_AW
//   overflow  sticky: a result was dropped because the FIFO was full
//
// Build option
//   FOS_DECIM_ROUND_EN
//     Defined: results round half toward +inf and saturate at the positive
//     DATA_W limit.
//     Undefined: results truncate toward -inf.

module fos_out_decim #(
    parameter int DATA_W  = 32,
    parameter int LOG2_N  = 2,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] y_in,
    input  logic              in_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FIFO_AW:0]  level,
    output logic              overflow
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int PH_W  = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'((1 << LOG2_N) - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    logic signed [ACC_W-1:0] r_acc;
    logic [PH_W-1:0]         r_phase;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0]      r_wr_ptr;
    logic [FIFO_AW-1:0]      r_rd_ptr;
    logic [FIFO_AW:0]        r_level;
    logic                    r_overflow;

    logic signed [ACC_W-1:0] w_y_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [DATA_W-1:0]       w_result;
    logic                    w_last;
    logic                    w_frame_done;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;

    // The accumulator carries LOG2_N guard bits, so the full-frame sum never wraps.
    assign w_y_ext = ACC_W'($signed(y_in));
    assign w_sum   = r_acc + w_y_ext;

`ifdef FOS_DECIM_ROUND_EN
    // One extra bit absorbs the rounding addend.
    // Only the positive limit can be exceeded after the shift.
    localparam logic signed [ACC_W:0] RND_ADD  = (ACC_W + 1)'((1 << LOG2_N) >> 1);
    localparam logic signed [ACC_W:0] DATA_MAX = (ACC_W + 1)'({1'b0, {(DATA_W - 1){1'b1}}});

    logic signed [ACC_W:0] w_sum_r;
    logic signed [ACC_W:0] w_shr_r;

    assign w_sum_r  = (ACC_W + 1)'(w_sum) + RND_ADD;
    assign w_shr_r  = w_sum_r >>> LOG2_N;
    assign w_result = (w_shr_r > DATA_MAX) ? DATA_W'(DATA_MAX) : DATA_W'(w_shr_r);
`else
    assign w_result = DATA_W'(w_sum >>> LOG2_N);
`endif

    assign w_last       = (r_phase == PH_LAST);
    assign w_frame_done = in_en & w_last;
    assign w_full       = (r_level == LVL_FULL);
    assign w_pop        = m_valid & m_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push       = w_frame_done & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (in_en) begin
            if (w_last) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
                2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_frame_done && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset.
    // Stale entries are unreachable because the pointers and level reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign m_valid  = (r_level != '0);
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fos_out_decim.sv
module tb_fos_out_decim;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] y_in;
    logic        in_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  level;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        exp_ovf = 1'b0;

    fos_out_decim #(.DATA_W(32), .LOG2_N(2), .FIFO_AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .y_in     (y_in),
        .in_en    (in_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

`ifdef FOS_DECIM_ROUND_EN
    localparam logic [31:0] EXP_POS = 32'd3;
    localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_POS = 32'd2;
    localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFE;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("level", {29'd0, level}, q.size());
        chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (q.size() == 0) chk("m_data_idle", m_data, 32'd0);
    endtask

    // Called just after a falling edge.
    // Drives one cycle, checks any pop, applies the expected push, then checks state.
    task automatic step(input logic [31:0] y, input logic en, input logic rdy,
                        input logic do_push, input logic [31:0] val);
        logic [31:0] e;
        y_in = y; in_en = en; m_ready = rdy;
        #1;
        if (rdy && q.size() != 0) begin
            e = q.pop_front();
            chk("pop_data", m_data, e);
        end
        if (do_push) begin
            if (q.size() < DEPTH) q.push_back(val);
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] exp,
                         input logic rdy, input logic rdy_last);
        step(a, 1'b1, rdy, 1'b0, 32'd0);
        step(b, 1'b1, rdy, 1'b0, 32'd0);
        step(c, 1'b1, rdy, 1'b0, 32'd0);
        step(d, 1'b1, rdy_last, 1'b1, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_en = 1'b1; y_in = 32'd7; m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_en = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) step(32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("drain_done", {31'd0, m_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; y_in = '0; in_en = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Truncation / rounding of a small positive frame.
        frame(32'd1, 32'd2, 32'd3, 32'd4, EXP_POS, 1'b1, 1'b1);
        drain();

        // Negative values.
        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, EXP_NEG, 1'b1, 1'b1);
        drain();

        // Positive extreme with a three-cycle gap inside the frame.
        step(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd0);
        step(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (3) step(32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'd0);
        step(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd0);
        step(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF);
        drain();

        // Negative extreme.
        frame(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        drain();

        // Backpressure: the fifth result is dropped and overflow sets.
        for (int k = 1; k <= 5; k++)
            frame(32'(10 * k), 32'(10 * k), 32'(10 * k), 32'(10 * k), 32'(10 * k), 1'b0, 1'b0);
        chk("ovf_after_5", {31'd0, overflow}, 32'd1);
        drain();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with a pop on the completion edge: the push is accepted.
        do_reset();
        for (int k = 1; k <= 4; k++)
            frame(32'(10 * k), 32'(10 * k), 32'(10 * k), 32'(10 * k), 32'(10 * k), 1'b0, 1'b0);
        frame(32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 1'b0, 1'b1);
        chk("full_pop_level", {29'd0, level}, 32'd4);
        chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
        drain();

        // Reset in the middle of a frame drops the partial sum.
        step(32'd7, 1'b1, 1'b1, 1'b0, 32'd0);
        step(32'd7, 1'b1, 1'b1, 1'b0, 32'd0);
        do_reset();
        frame(32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
